// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation controller and round logic.
// No logic of its own; zero latency.
// No handshake; carries the types used by the valid/ready datapath.
package ascon_pkg;

  // Rounds computed per clock by asconp; the controller steps round_cnt by this.
  localparam int UROL = 1;
  // Round constants are indexed 0..11, so a count above this breaks them.
  localparam int MAX_ROUNDS = 12;

  typedef logic [3:0] round_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perm_fsm_t;

  // x0 occupies the most significant word.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl_asconp.sv
// Combinational Ascon-p: UROL rounds per pass, constant index = 0xC - round_cnt.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the controller decides when the result is registered.
module asconp
  import ascon_pkg::*;
(
  input  ascon_state_t state_in,
  input  round_cnt_t   round_cnt,
  output ascon_state_t state_out
);

  function automatic ascon_state_t round_f(input ascon_state_t s, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s.x0;
    x1 = s.x1;
    x2 = s.x2 ^ {56'd0, c};
    x3 = s.x3;
    x4 = s.x4;
    // Bitsliced 5-bit S-box
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Per-word linear diffusion
    return {x0 ^ ror64(x0, 19) ^ ror64(x0, 28),
            x1 ^ ror64(x1, 61) ^ ror64(x1, 39),
            x2 ^ ror64(x2, 1)  ^ ror64(x2, 6),
            x3 ^ ror64(x3, 10) ^ ror64(x3, 17),
            x4 ^ ror64(x4, 7)  ^ ror64(x4, 41)};
  endfunction

  ascon_state_t s_acc;
  round_cnt_t   idx;

  // Chain UROL rounds; a count of R selects the last R constants of p^12.
  always_comb begin
    s_acc = state_in;
    idx   = 4'hC - round_cnt;
    for (int k = 0; k < UROL; k++) begin
      idx   = 4'hC - round_cnt + 4'(k);
      s_acc = round_f(s_acc, {4'hF - idx, idx});
    end
    state_out = s_acc;
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Owns the 320-bit Ascon state and iterates asconp to complete p^a or p^b.
// Latency: out_valid rises R/UROL cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        rounds_sel,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  output logic        busy
);

  if ((ROUNDS_A % UROL) != 0 || ROUNDS_A > MAX_ROUNDS || ROUNDS_A == 0) begin : g_bad_rounds_a
    $error("ROUNDS_A must be a nonzero multiple of UROL and at most 12");
  end
  if ((ROUNDS_B % UROL) != 0 || ROUNDS_B > MAX_ROUNDS || ROUNDS_B == 0) begin : g_bad_rounds_b
    $error("ROUNDS_B must be a nonzero multiple of UROL and at most 12");
  end

  perm_fsm_t    fsm_q;
  ascon_state_t state_q;
  ascon_state_t state_nxt;
  round_cnt_t   round_cnt_q;
  round_cnt_t   load_cnt;
  logic         out_valid_q;
  logic         busy_q;

  asconp u_asconp (
    .state_in  (state_q),
    .round_cnt (round_cnt_q),
    .state_out (state_nxt)
  );

  assign load_cnt  = rounds_sel ? round_cnt_t'(ROUNDS_B) : round_cnt_t'(ROUNDS_A);
  // Ready in DONE only when the result leaves this cycle, so a new job can overlap the handoff.
  assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign x0_o      = state_q.x0;
  assign x1_o      = state_q.x1;
  assign x2_o      = state_q.x2;
  assign x3_o      = state_q.x3;
  assign x4_o      = state_q.x4;

  // Controller FSM with state register, round counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_cnt_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= {x0_i, x1_i, x2_i, x3_i, x4_i};
            round_cnt_q <= load_cnt;
            fsm_q       <= RUN;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          state_q     <= state_nxt;
          round_cnt_q <= round_cnt_q - round_cnt_t'(UROL);
          if (round_cnt_q == round_cnt_t'(UROL)) begin
            fsm_q       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              state_q     <= {x0_i, x1_i, x2_i, x3_i, x4_i};
              round_cnt_q <= load_cnt;
              fsm_q       <= RUN;
              busy_q      <= 1'b1;
            end else begin
              fsm_q <= IDLE;
            end
          end
        end
        default: begin
          fsm_q       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: table-driven Ascon-p reference model.
// Checks reset, p^12/p^6 vectors, latency, busy, backpressure, back-to-back, reset mid-run.
// Random in_valid/out_ready stress over 1000 jobs.
module tb_ascon_perm_ctrl;
  import ascon_pkg::*;

  localparam int RA = 12;
  localparam int RB = 6;
  localparam logic [319:0] IV_STATE = {64'h80400C0600000000, 256'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, rounds_sel, out_valid, out_ready, busy;
  logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  logic [319:0] st_o;

  assign st_o = {x0_o, x1_o, x2_o, x3_o, x4_o};

  ascon_perm_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .rounds_sel(rounds_sel),
    .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk = 0;
  int n_pass = 0;
  int n_rel = 0;
  int busy_cnt = 0;
  bit prev_ov = 1'b0;
  logic [319:0] q_exp[$];
  int q_edge[$];
  int q_r[$];

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Reference Ascon-p: last `rounds` rounds of p^12, S-box by lookup table.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int rounds);
    logic [63:0] w[5];
    logic [63:0] n[5];
    logic [4:0]  v, o;
    logic [7:0]  c;
    for (int i = 0; i < 5; i++) w[i] = s[319 - 64*i -: 64];
    for (int r = 12 - rounds; r < 12; r++) begin
      c = 8'(((15 - r) << 4) | r);
      w[2][7:0] = w[2][7:0] ^ c;
      for (int b = 0; b < 64; b++) begin
        v = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
        o = sbox(v);
        for (int i = 0; i < 5; i++) n[i][b] = o[4 - i];
      end
      w[0] = n[0] ^ rot(n[0], 19) ^ rot(n[0], 28);
      w[1] = n[1] ^ rot(n[1], 61) ^ rot(n[1], 39);
      w[2] = n[2] ^ rot(n[2], 1)  ^ rot(n[2], 6);
      w[3] = n[3] ^ rot(n[3], 10) ^ rot(n[3], 17);
      w[4] = n[4] ^ rot(n[4], 7)  ^ rot(n[4], 41);
    end
    return {w[0], w[1], w[2], w[3], w[4]};
  endfunction

  // One cycle: drive at negedge, sample 1 time unit later, score handshakes due at next posedge.
  task automatic cyc_drive(input bit iv, input logic [319:0] st, input bit sel, input bit ordy,
                           output bit acc, output bit rel);
    int r;
    @(negedge clk);
    in_valid = iv;
    {x0_i, x1_i, x2_i, x3_i, x4_i} = st;
    rounds_sel = sel;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    rel = out_valid && out_ready;
    if (out_valid && !prev_ov) begin
      check_eq("rise_has_job", 320'(q_edge.size() != 0), 320'd1);
      if (q_edge.size() != 0) begin
        check_eq("latency", cyc_n - q_edge[0], q_r[0] / UROL);
        check_eq("busy_cycles", busy_cnt, q_r[0] / UROL);
      end
    end
    if (acc) busy_cnt = 0;
    else if (busy) busy_cnt++;
    prev_ov = out_valid;
    if (rel) begin
      check_eq("pop_nonempty", 320'(q_exp.size() != 0), 320'd1);
      if (q_exp.size() != 0) begin
        check_eq("data", st_o, q_exp.pop_front());
        void'(q_edge.pop_front());
        void'(q_r.pop_front());
      end
      n_rel++;
    end
    if (acc) begin
      r = sel ? RB : RA;
      q_exp.push_back(ref_perm(st, r));
      q_edge.push_back(cyc_n + 1);
      q_r.push_back(r);
    end
  endtask

  task automatic drain();
    bit acc, rel;
    int guard = 0;
    while (q_exp.size() != 0 && guard < 200) begin
      cyc_drive(1'b0, '0, 1'b0, 1'b1, acc, rel);
      guard++;
    end
    check_eq("drain_done", q_exp.size(), 0);
  endtask

  task automatic offer(input logic [319:0] st, input bit sel, input bit ordy);
    bit acc, rel;
    int guard = 0;
    acc = 1'b0;
    while (!acc && guard < 100) begin
      cyc_drive(1'b1, st, sel, ordy, acc, rel);
      guard++;
    end
    check_eq("accepted", acc, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, rel, pend, psel, ordy;
    logic [319:0] pst, st2;
    int sent, guard, ov_cnt, rel_base;

    rst_n = 1'b0; in_valid = 1'b0; rounds_sel = 1'b0; out_ready = 1'b0;
    {x0_i, x1_i, x2_i, x3_i, x4_i} = '0;
    #23;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_state", st_o, 0);
    @(negedge clk); rst_n = 1'b1;

    // p^12 and p^6 on the Ascon-128 IV word
    offer(IV_STATE, 1'b0, 1'b1);
    drain();
    offer(IV_STATE, 1'b1, 1'b1);
    drain();

    // Backpressure in DONE, then simultaneous handoff and accept
    st2 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h1, 64'h2, 64'h3};
    offer(IV_STATE, 1'b0, 1'b0);
    guard = 0;
    while (!out_valid && guard < 40) begin
      cyc_drive(1'b0, '0, 1'b0, 1'b0, acc, rel);
      guard++;
    end
    check_eq("bp_reached_done", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      cyc_drive(1'b1, st2, 1'b1, 1'b0, acc, rel);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_accept", acc, 0);
      if (q_exp.size() != 0) check_eq("bp_state", st_o, q_exp[0]);
    end
    cyc_drive(1'b1, st2, 1'b1, 1'b1, acc, rel);
    check_eq("b2b_same_cycle", {acc, rel}, 2'b11);
    drain();

    // Reset in the middle of a p^12 run discards the job
    offer(IV_STATE, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc_drive(1'b0, '0, 1'b0, 1'b1, acc, rel);
    check_eq("pre_rst_busy", busy, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_state", st_o, 0);
    q_exp.delete(); q_edge.delete(); q_r.delete();
    prev_ov = 1'b0;
    @(negedge clk); #2; rst_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc_drive(1'b0, '0, 1'b0, 1'b1, acc, rel);
      if (out_valid) ov_cnt++;
    end
    check_eq("no_spurious_out", ov_cnt, 0);

    // Random stress
    rel_base = n_rel;
    sent = 0; guard = 0; pend = 1'b0; psel = 1'b0; pst = '0;
    while (sent < 1000 && guard < 60000) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 10; i++) pst[32*i +: 32] = $urandom();
        psel = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      cyc_drive(pend, pst, psel, ordy, acc, rel);
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
      guard++;
    end
    check_eq("stress_sent", sent, 1000);
    drain();
    check_eq("stress_released", n_rel - rel_base, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
